a2d_spi_resp: RTL and testbench
===============================

# a2d_spi_resp

SPI responder modelling the 8-channel, 12-bit A2D converter at the far end of the A2D interface's SPI link. It decodes the channel field of each 16-bit command frame and returns the conversion for the previously addressed channel in the following frame. Conversion values come from an external per-channel lookup. The block sits in the fullchip bench, and optionally in an FPGA self-test build, opposite the Segway's A2D master: it drives `A2D_MISO` and consumes `A2D_SS_n`, `A2D_SCLK` and `A2D_MOSI`.

## Interface
- `DATA_W`, default 12: conversion width; the response frame is `{(16-DATA_W)'b0, data}`.
- `clk` input, 1: system clock; all state is on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `SS_n` input, 1: slave select from the master, active low, asynchronous to `clk`.
- `SCLK` input, 1: serial clock from the master, mode 0, idles low, asynchronous to `clk`.
- `MOSI` input, 1: command bits, MSB first.
- `MISO` output, 1: response bits, MSB first; driven 0 while deselected.
- `rd_ch` output, 3: channel currently selected for response; drives the lookup.
- `rd_data` input, DATA_W: conversion value for `rd_ch`, combinational from outside.
- `cmd_vld` output, 1: one-clk pulse when a complete 16-bit frame is accepted.
- `cmd_ch` output, 3: channel decoded from the last accepted frame; valid with `cmd_vld` and held afterwards.
- `frm_err` output, 1: one-clk pulse when `SS_n` deasserts after a bit count other than 16.

## Operation
- `SS_n`, `SCLK` and `MOSI` each pass through a 2-flop synchronizer. The block compares the synchronized `SCLK` and `SS_n` against a third registered copy to produce `sclk_rise`, `sclk_fall`, `ss_fall` and `ss_rise` strobes.
- State machine has two states:
  - IDLE → SHIFT on `ss_fall`:
    - `tx_shft <= {0, rd_data}`.
    - `bit_cnt <= 0`.
  - In SHIFT:
    - On `sclk_rise`: `rx_shft <= {rx_shft[14:0], MOSI_sync}` and `bit_cnt++`. The counter saturates at 16; extra edges are ignored.
    - On `sclk_fall`, when `bit_cnt` is between 1 and 15: `tx_shft <= {tx_shft[14:0], 1'b0}`.
  - SHIFT → IDLE on `ss_rise`:
    - If `bit_cnt == 16`: `ch_reg <= rx_shft[13:11]`, `cmd_ch <= rx_shft[13:11]`, and `cmd_vld` pulses.
    - Otherwise: `frm_err` pulses and `ch_reg` is unchanged.
- `rd_ch = ch_reg`. The response always reflects the channel addressed in the previous accepted frame, which is pipelined converter behaviour.
- `MISO = (state == SHIFT) ? tx_shft[15] : 0`.
- Command bits [15:14] and [10:0] are ignored; no check is made.
- `ss_fall` while already in SHIFT has no effect. `ss_rise` while in IDLE has no effect.
- Reset in the middle of a frame returns the block to IDLE. The remaining `SCLK` edges of that frame are ignored until the next `ss_fall`.

## Timing
- Reset values:
  - State is IDLE.
  - `MISO`, `cmd_vld` and `frm_err` are 0.
  - `ch_reg`, `cmd_ch` and `rd_ch` are 0.
  - `tx_shft`, `rx_shft` and `bit_cnt` are 0.
  - All synchronizer flops are reset high for `SS_n` and low for `SCLK`/`MOSI`.
- Pin-to-strobe latency is 3 clk.
- The first response bit appears on `MISO` 4 clk after the `SS_n` pin falls.
- Next bit is valid 4 clk after each `SCLK` pin fall.
- Master requirements:
  - `SCLK` high and low phases each at least 4 clk.
  - `SS_n` low to first `SCLK` rise at least 5 clk.
  - `SS_n` high time at least 4 clk.
  - The A2D master's `SCLK` of clk/32 satisfies all of these.
- `rd_data` is sampled exactly once, on the `ss_fall` cycle. Later changes do not alter the frame in flight.
- `cmd_vld` and `frm_err` occur 3 clk after the `SS_n` pin rises. They are never asserted together.

## Structure
- Package `a2d_spi_pkg` holds:
  - `FRAME_BITS = 16`, `CH_MSB = 13`, `CH_LSB = 11`.
  - State enum `{IDLE, SHIFT}`.
- One sub-module, `spi_edge_sync`: a 3-flop synchronizer plus rise/fall strobes with a reset-value parameter. It is instantiated for `SS_n` and `SCLK`. `MOSI` uses only the 2-flop part.

## Test plan
- Reset, then idle with `SS_n` high: `MISO`=0, `rd_ch`=0, no pulses.
- Frame 1 sends 16'h1800 (channel 3), `rd_data`=12'hABC for channel 0. Required:
  - `MISO` returns 16'h0ABC.
  - `cmd_vld` pulses with `cmd_ch`=3.
  - `rd_ch`=3 afterwards.
- Frame 2 sends any value with the lookup giving channel 3 = 12'h123: response is 16'h0123.
- Abort after 9 `SCLK` pulses: `frm_err` pulses, `cmd_vld` stays low, `rd_ch` is unchanged.
- Change `rd_data` mid-frame: the response frame is unchanged.
- Assert `rst_n` low at bit 7: `MISO` goes to 0 immediately and `rd_ch`=0. The next full frame behaves as in the channel-3 frame scenario.

Source files
------------

// File: rtl/a2d_spi_pkg.sv
// Shared constants and state type for the A2D SPI responder model.
package a2d_spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CH_MSB     = 13;
    localparam int CH_LSB     = 11;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Three-flop synchronizer for an asynchronous pin with rise/fall strobes
// taken between the synchronized copy and one extra registered copy.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe <= {3{RST_VAL}};
        else        sync_pipe <= {sync_pipe[1:0], d};
    end

    assign rise =  sync_pipe[1] & ~sync_pipe[2];
    assign fall = ~sync_pipe[1] &  sync_pipe[2];

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder for the 8-channel A2D: decodes the channel of each command
// frame and returns the conversion of the previously addressed channel.
module a2d_spi_resp
    import a2d_spi_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic [2:0]        rd_ch,
    input  logic [DATA_W-1:0] rd_data,
    output logic              cmd_vld,
    output logic [2:0]        cmd_ch,
    output logic              frm_err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [1:0] mosi_pipe;
    logic       mosi_sync;

    state_t                  state, state_nxt;
    logic [FRAME_BITS-1:0]   tx_shft, rx_shft;
    logic [CNT_W-1:0]        bit_cnt;
    logic [2:0]              ch_reg;
    logic                    frame_ok, frame_bad, miso_nxt;

    spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (SS_n),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (SCLK),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // MOSI is only sampled, so two flops keep it aligned with the SCLK strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_pipe <= 2'b00;
        else        mosi_pipe <= {mosi_pipe[0], MOSI};
    end
    assign mosi_sync = mosi_pipe[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = SHIFT;
            SHIFT:   if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_ok  = (state == SHIFT) && ss_rise && (bit_cnt == CNT_FULL);
        frame_bad = (state == SHIFT) && ss_rise && (bit_cnt != CNT_FULL);
        miso_nxt  = (state == SHIFT) ? tx_shft[FRAME_BITS-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MISO    <= 1'b0;
            cmd_vld <= 1'b0;
            frm_err <= 1'b0;
            cmd_ch  <= 3'd0;
            ch_reg  <= 3'd0;
            tx_shft <= '0;
            rx_shft <= '0;
            bit_cnt <= '0;
        end else begin
            MISO    <= miso_nxt;
            cmd_vld <= frame_ok;
            frm_err <= frame_bad;
            if (frame_ok) begin
                ch_reg <= rx_shft[CH_MSB:CH_LSB];
                cmd_ch <= rx_shft[CH_MSB:CH_LSB];
            end
            case (state)
                IDLE: if (ss_fall) begin
                    tx_shft <= FRAME_BITS'(rd_data);
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    // counter saturates at a full frame; surplus edges are dropped
                    if (sclk_rise && bit_cnt != CNT_FULL) begin
                        rx_shft <= {rx_shft[FRAME_BITS-2:0], mosi_sync};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (sclk_fall && bit_cnt != '0 && bit_cnt != CNT_FULL)
                        tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign rd_ch = ch_reg;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: bit-banged SPI master, channel lookup model and
// a response scoreboard.
module tb_a2d_spi_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [2:0]  rd_ch;
    logic [11:0] rd_data;
    logic        cmd_vld;
    logic [2:0]  cmd_ch;
    logic        frm_err;

    logic [11:0] lut [8];
    logic [15:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          vld_cnt = 0;
    int          err_cnt = 0;
    int          both_cnt = 0;
    int          last_lat = 0;
    logic [2:0]  model_ch = 3'd0;

    a2d_spi_resp #(.DATA_W(12)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .rd_ch   (rd_ch),
        .rd_data (rd_data),
        .cmd_vld (cmd_vld),
        .cmd_ch  (cmd_ch),
        .frm_err (frm_err)
    );

    assign rd_data = lut[rd_ch];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_vld) vld_cnt++;
        if (frm_err) err_cnt++;
        if (cmd_vld && frm_err) both_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One SPI mode-0 transfer; MISO captured on each SCLK rise.
    task automatic xfer(input logic [15:0] cmd, input int nbits, input int chg_at,
                        input int chg_ch, input logic [11:0] chg_val, input int rst_at,
                        output logic [15:0] resp);
        resp = 16'h0;
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? cmd[15-i] : 1'b1;
            repeat (16) @(negedge clk);
            SCLK = 1'b1;
            if (i < 16) resp[15-i] = MISO;
            if (i == chg_at) lut[chg_ch] = chg_val;
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_miso", {31'b0, MISO}, 32'h0);
                chk("rst_rd_ch", {29'b0, rd_ch}, 32'h0);
                chk("rst_cmd_ch", {29'b0, cmd_ch}, 32'h0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (16) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (8) @(negedge clk);
        SS_n = 1'b1;
        last_lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (last_lat == 0 && (cmd_vld || frm_err)) last_lat = k;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic good_frame(input string tag, input logic [15:0] cmd, input int nbits,
                              input int chg_at, input int chg_ch, input logic [11:0] chg_val);
        logic [15:0] resp, exp;
        logic [2:0]  ch;
        int          v0, e0;
        exp_q.push_back({4'h0, lut[model_ch]});
        v0 = vld_cnt;
        e0 = err_cnt;
        xfer(cmd, nbits, chg_at, chg_ch, chg_val, -1, resp);
        exp = exp_q.pop_front();
        ch  = cmd[13:11];
        chk({tag, "_resp"}, {16'b0, resp}, {16'b0, exp});
        chk({tag, "_vld_pulses"}, vld_cnt - v0, 1);
        chk({tag, "_err_pulses"}, err_cnt - e0, 0);
        chk({tag, "_cmd_ch"}, {29'b0, cmd_ch}, {29'b0, ch});
        chk({tag, "_rd_ch"}, {29'b0, rd_ch}, {29'b0, ch});
        chk({tag, "_lat"}, last_lat, 3);
        chk({tag, "_miso_idle"}, {31'b0, MISO}, 32'h0);
        model_ch = ch;
    endtask

    initial begin
        logic [15:0] resp;
        int          v0, e0;

        for (int i = 0; i < 8; i++) lut[i] = 12'h000;
        repeat (3) @(negedge clk);
        chk("reset_miso", {31'b0, MISO}, 32'h0);
        chk("reset_rd_ch", {29'b0, rd_ch}, 32'h0);
        chk("reset_cmd_vld", {31'b0, cmd_vld}, 32'h0);
        chk("reset_frm_err", {31'b0, frm_err}, 32'h0);
        rst_n = 1'b1;
        v0 = vld_cnt;
        e0 = err_cnt;
        repeat (20) @(negedge clk);
        chk("idle_miso", {31'b0, MISO}, 32'h0);
        chk("idle_pulses", (vld_cnt - v0) + (err_cnt - e0), 0);

        lut[0] = 12'hABC;
        lut[3] = 12'h123;
        good_frame("f1_ch3", 16'h1800, 16, -1, 0, 12'h0);
        good_frame("f2_ch7", 16'h7800, 16, -1, 0, 12'h0);

        v0 = vld_cnt;
        e0 = err_cnt;
        xfer(16'h0000, 9, -1, 0, 12'h0, -1, resp);
        chk("abort_err_pulses", err_cnt - e0, 1);
        chk("abort_vld_pulses", vld_cnt - v0, 0);
        chk("abort_rd_ch", {29'b0, rd_ch}, {29'b0, model_ch});
        chk("abort_lat", last_lat, 3);

        lut[7] = 12'h456;
        good_frame("midchg", 16'h0800, 16, 5, 7, 12'hFFF);

        lut[1] = 12'h800;
        good_frame("extra_edges", 16'h1000, 17, -1, 0, 12'h0);

        lut[2] = 12'hFFF;
        good_frame("full_ones", 16'hB800, 16, -1, 0, 12'h0);
        lut[7] = 12'h000;
        good_frame("all_zero", 16'h1800, 16, -1, 0, 12'h0);

        xfer(16'hFFFF, 16, -1, 0, 12'h0, 7, resp);
        model_ch = 3'd0;
        lut[0] = 12'hABC;
        good_frame("post_rst", 16'h1800, 16, -1, 0, 12'h0);

        chk("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
